dwt_input_collector: RTL and testbench

- Streaming front-end for the pipelined Haar DWT core. Accepts 16-bit Q8.8 samples one per cycle over a valid/ready handshake and packs them into N-sample frames in a ping-pong (two-bank) buffer.
- Presents each full frame on the core's flat array input and drives the core's level-sensitive start/done protocol.
- Overlaps filling the next frame with processing of the current one.

---
 rtl/dwt_input_collector.sv | 143 ++++++++++++++
 tb/tb_dwt_input_collector.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwt_input_collector.sv
// Streaming front-end for the Haar DWT core: packs samples into N-sample frames
// across two ping-pong banks and runs the core's level start/done handshake.
module dwt_input_collector #(
    parameter int unsigned N = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [15:0]     s_data,
    input  logic            s_last,
    output logic [N*16-1:0] array_out,
    output logic            start,
    input  logic            done,
    output logic            frame_done,
    output logic            busy
);

    localparam int unsigned CntW = $clog2(N);

    typedef enum logic [1:0] {
        HsIdle,
        HsStart,
        HsRelease
    } hs_state_e;

    logic [15:0]     bank_q [2][N];
    logic [15:0]     bank_d [2][N];
    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
    hs_state_e       hs_q, hs_d;
    logic            start_q, start_d;
    logic            frame_done_q, frame_done_d;

    logic accept;
    logic close;

    assign s_ready = ~full_q[wr_bank_q];
    assign accept  = s_valid & s_ready;
    assign close   = accept & (s_last | (wr_cnt_q == CntW'(N - 1)));

    // Write side: store the sample; an s_last close zero-fills the tail of the bank.
    always_comb begin
        bank_d    = bank_q;
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (accept) begin
            for (int k = 0; k < N; k++) begin
                if (CntW'(k) == wr_cnt_q) begin
                    bank_d[wr_bank_q][k] = s_data;
                end else if (s_last && (CntW'(k) > wr_cnt_q)) begin
                    bank_d[wr_bank_q][k] = 16'h0000;
                end
            end
            if (close) begin
                wr_cnt_d  = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_cnt_d  = wr_cnt_q + 1'b1;
            end
        end
    end

    // Handshake FSM plus full flags; close and release touch different banks.
    always_comb begin
        hs_d         = hs_q;
        start_d      = start_q;
        frame_done_d = 1'b0;
        full_d       = full_q;
        rd_bank_d    = rd_bank_q;
        if (close) begin
            full_d[wr_bank_q] = 1'b1;
        end
        unique case (hs_q)
            HsIdle: begin
                // A stale done from a previous run must fall before we request again.
                if (full_q[rd_bank_q] && !done) begin
                    start_d = 1'b1;
                    hs_d    = HsStart;
                end
            end
            HsStart: begin
                if (done) begin
                    start_d      = 1'b0;
                    frame_done_d = 1'b1;
                    hs_d         = HsRelease;
                end
            end
            HsRelease: begin
                if (!done) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    hs_d              = HsIdle;
                end
            end
            default: begin
                hs_d = HsIdle;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < N; k++) begin
                    bank_q[b][k] <= 16'h0000;
                end
            end
            full_q       <= 2'b00;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_cnt_q     <= '0;
            hs_q         <= HsIdle;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            full_q       <= full_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_cnt_q     <= wr_cnt_d;
            hs_q         <= hs_d;
            start_q      <= start_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Flatten the read bank onto the core's array input.
    always_comb begin
        array_out = '0;
        for (int k = 0; k < N; k++) begin
            array_out[k*16 +: 16] = bank_q[rd_bank_q][k];
        end
    end

    assign start      = start_q;
    assign frame_done = frame_done_q;
    assign busy       = (|full_q) | start_q | (hs_q != HsIdle);

endmodule

// File: tb/tb_dwt_input_collector.sv
// Directed bench for dwt_input_collector with a simple behavioural core model.
module tb_dwt_input_collector;

    localparam int N = 8;
    localparam int W = N * 16;

    logic         clk;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [15:0]  s_data;
    logic         s_last;
    logic [W-1:0] array_out;
    logic         start;
    logic         done;
    logic         frame_done;
    logic         busy;

    dwt_input_collector #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .array_out  (array_out),
        .start      (start),
        .done       (done),
        .frame_done (frame_done),
        .busy       (busy)
    );

    int nvec = 0;
    int nerr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: either driven by hand (man_done) or an automatic fixed-latency core.
    logic         auto_en = 1'b0;
    logic         man_done = 1'b0;
    int           core_lat = 10;
    logic         core_done;
    logic         core_active;
    int           core_cnt;
    logic [W-1:0] cap_q [$];
    logic [W-1:0] exp_q [$];

    assign done = auto_en ? core_done : man_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_done   <= 1'b0;
            core_active <= 1'b0;
            core_cnt    <= 0;
        end else if (auto_en) begin
            if (!core_active && start && !core_done) begin
                core_active <= 1'b1;
                core_cnt    <= 0;
                cap_q.push_back(array_out);
            end else if (core_active && !core_done) begin
                if (core_cnt >= core_lat) core_done <= 1'b1;
                else core_cnt <= core_cnt + 1;
            end else if (core_done && !start) begin
                core_done   <= 1'b0;
                core_active <= 1'b0;
            end
        end
    end

    // Event counters for start rises and frame_done pulses.
    int   st_cnt = 0;
    int   fd_cnt = 0;
    logic start_prev = 1'b0;
    always @(posedge clk) begin
        start_prev <= start;
        if (start && !start_prev) st_cnt <= st_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    // Reference frame builder, fed by the driver on every accepted sample.
    logic [W-1:0] cur_frame = '0;
    int           cur_cnt   = 0;
    logic         stall_seen = 1'b0;

    task automatic send_sample(input logic [15:0] d, input logic last);
        int w;
        w = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && w < 300) begin
            stall_seen = 1'b1;
            @(negedge clk);
            w++;
        end
        nvec++;
        if (!s_ready) begin
            nerr++;
            $display("FAIL accept_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, w);
        end else begin
            @(posedge clk);
            cur_frame[cur_cnt*16 +: 16] = d;
            if (last || cur_cnt == N - 1) begin
                exp_q.push_back(cur_frame);
                cur_frame = '0;
                cur_cnt   = 0;
            end else begin
                cur_cnt++;
            end
        end
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        @(negedge clk);
        while ((busy || done) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        nvec++;
        if (busy || done) begin
            nerr++;
            $display("FAIL drain_timeout: busy=%0b done=%0b, required 0/0", busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        #12;
        nvec++; if (start !== 1'b0) begin nerr++; $display("FAIL rst_start: got %0b want 0", start); end
        nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL rst_fd: got %0b want 0", frame_done); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %0b want 0", busy); end
        nvec++; if (s_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %0b want 1", s_ready); end
        nvec++; if (array_out !== '0) begin nerr++; $display("FAIL rst_array: got %h want 0", array_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        int fd0;
        fd0 = fd_cnt;
        exp_q.delete();
        for (int i = 0; i < N; i++) send_sample(16'((i + 1) * 16'h0100), 1'b0);
        nvec++; if (start !== 1'b0) begin nerr++; $display("FAIL sf_start_early: got %0b want 0", start); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL sf_busy: got %0b want 1", busy); end
        @(posedge clk); #1;
        nvec++; if (start !== 1'b1) begin nerr++; $display("FAIL sf_start: got %0b want 1", start); end
        nvec++; if (array_out[15:0] !== 16'h0100) begin nerr++; $display("FAIL sf_lo: got %h want 0100", array_out[15:0]); end
        nvec++; if (array_out[127:112] !== 16'h0800) begin nerr++; $display("FAIL sf_hi: got %h want 0800", array_out[127:112]); end
        nvec++; if (array_out !== exp_q[0]) begin nerr++; $display("FAIL sf_frame: got %h want %h", array_out, exp_q[0]); end
        @(negedge clk); man_done = 1'b1;
        @(posedge clk); #1;
        nvec++; if (frame_done !== 1'b1 || start !== 1'b0) begin
            nerr++; $display("FAIL sf_done: fd=%0b start=%0b want 1/0", frame_done, start); end
        @(posedge clk); #1;
        nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL sf_fd_once: got %0b want 0", frame_done); end
        @(negedge clk); man_done = 1'b0;
        @(posedge clk); #1;
        nvec++; if (busy !== 1'b0 || s_ready !== 1'b1) begin
            nerr++; $display("FAIL sf_release: busy=%0b ready=%0b want 0/1", busy, s_ready); end
        nvec++; if (fd_cnt - fd0 !== 1) begin nerr++; $display("FAIL sf_fd_count: got %0d want 1", fd_cnt - fd0); end
    endtask

    task automatic test_short_frame();
        logic [W-1:0] want;
        want = 128'h0000_0000_0000_0000_0000_0300_0200_0100;
        send_sample(16'h0100, 1'b0);
        send_sample(16'h0200, 1'b0);
        send_sample(16'h0300, 1'b1);
        @(posedge clk); #1;
        nvec++; if (start !== 1'b1) begin nerr++; $display("FAIL short_start: got %0b want 1", start); end
        nvec++; if (array_out !== want) begin nerr++; $display("FAIL short_frame: got %h want %h", array_out, want); end
        @(negedge clk); man_done = 1'b1;
        @(negedge clk); man_done = 1'b0;
        wait_drain();
    endtask

    task automatic test_handshake_order();
        logic [W-1:0] fa, fb;
        exp_q.delete();
        @(negedge clk); man_done = 1'b1;  // stale done while idle
        for (int i = 0; i < 2 * N; i++) send_sample(16'(16'h1000 + i), 1'b0);
        fa = exp_q[0]; fb = exp_q[1];
        nvec++; if (s_ready !== 1'b0) begin nerr++; $display("FAIL hs_both_full: ready=%0b want 0", s_ready); end
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (start !== 1'b0) begin nerr++; $display("FAIL hs_stale_done: start=%0b want 0", start); end
        @(negedge clk); man_done = 1'b0;
        @(posedge clk); #1;
        nvec++; if (start !== 1'b1) begin nerr++; $display("FAIL hs_start_a: got %0b want 1", start); end
        nvec++; if (array_out !== fa) begin nerr++; $display("FAIL hs_frame_a: got %h want %h", array_out, fa); end
        @(negedge clk); man_done = 1'b1;
        @(posedge clk); #1;
        nvec++; if (frame_done !== 1'b1) begin nerr++; $display("FAIL hs_fd_a: got %0b want 1", frame_done); end
        @(negedge clk); man_done = 1'b0;
        @(posedge clk); #1;
        nvec++; if (s_ready !== 1'b1) begin nerr++; $display("FAIL hs_ready_after: got %0b want 1", s_ready); end
        @(posedge clk); #1;
        nvec++; if (start !== 1'b1) begin nerr++; $display("FAIL hs_start_b: got %0b want 1", start); end
        nvec++; if (array_out !== fb) begin nerr++; $display("FAIL hs_frame_b: got %h want %h", array_out, fb); end
        @(negedge clk); man_done = 1'b1;
        @(negedge clk); man_done = 1'b0;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int st0, fd0;
        exp_q.delete(); cap_q.delete();
        st0 = st_cnt; fd0 = fd_cnt;
        stall_seen = 1'b0;
        core_lat = 12;
        auto_en = 1'b1;
        for (int i = 0; i < 3 * N; i++) send_sample(16'(16'h2000 + i * 3), 1'b0);
        wait_drain();
        @(negedge clk);
        nvec++; if (stall_seen !== 1'b1) begin nerr++; $display("FAIL bp_stall: got %0b want 1", stall_seen); end
        nvec++; if (st_cnt - st0 !== 3) begin nerr++; $display("FAIL bp_starts: got %0d want 3", st_cnt - st0); end
        nvec++; if (fd_cnt - fd0 !== 3) begin nerr++; $display("FAIL bp_fd: got %0d want 3", fd_cnt - fd0); end
        nvec++; if (cap_q.size() !== 3) begin nerr++; $display("FAIL bp_frames: got %0d want 3", cap_q.size()); end
        for (int f = 0; f < cap_q.size() && f < exp_q.size(); f++) begin
            nvec++;
            if (cap_q[f] !== exp_q[f]) begin
                nerr++; $display("FAIL bp_data[%0d]: got %h want %h", f, cap_q[f], exp_q[f]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] want;
        core_lat = 40;
        for (int i = 0; i < N + N / 2; i++) send_sample(16'(16'h3000 + i), 1'b0);
        nvec++; if (start !== 1'b1) begin nerr++; $display("FAIL mr_pre_start: got %0b want 1", start); end
        #2; rst_n = 1'b0; #1;
        nvec++; if (start !== 1'b0) begin nerr++; $display("FAIL mr_start: got %0b want 0", start); end
        nvec++; if (s_ready !== 1'b1) begin nerr++; $display("FAIL mr_ready: got %0b want 1", s_ready); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mr_busy: got %0b want 0", busy); end
        nvec++; if (array_out !== '0) begin nerr++; $display("FAIL mr_array: got %h want 0", array_out); end
        exp_q.delete(); cap_q.delete(); cur_frame = '0; cur_cnt = 0;
        @(negedge clk); rst_n = 1'b1;
        core_lat = 6;
        for (int i = 0; i < N; i++) send_sample(16'(16'h0A00 + i), 1'b0);
        want = exp_q[0];
        wait_drain();
        nvec++; if (cap_q.size() !== 1) begin nerr++; $display("FAIL mr_frames: got %0d want 1", cap_q.size()); end
        nvec++; if (cap_q.size() > 0 && cap_q[0] !== want) begin
            nerr++; $display("FAIL mr_data: got %h want %h", cap_q[0], want); end
    endtask

    task automatic test_random_gaps();
        int fd0, nf, len;
        logic last;
        exp_q.delete(); cap_q.delete();
        fd0 = fd_cnt;
        nf = 20;
        core_lat = 5;
        for (int f = 0; f < nf; f++) begin
            len = $urandom_range(N, 1);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(3, 0)) @(negedge clk);
                last = (i == len - 1) && ((len < N) || ($urandom_range(1, 0) == 1));
                send_sample(16'($urandom), last);
            end
        end
        wait_drain();
        nvec++; if (fd_cnt - fd0 !== nf) begin nerr++; $display("FAIL rnd_fd: got %0d want %0d", fd_cnt - fd0, nf); end
        nvec++; if (cap_q.size() !== nf) begin nerr++; $display("FAIL rnd_frames: got %0d want %0d", cap_q.size(), nf); end
        for (int f = 0; f < cap_q.size() && f < exp_q.size(); f++) begin
            nvec++;
            if (cap_q[f] !== exp_q[f]) begin
                nerr++; $display("FAIL rnd_data[%0d]: got %h want %h", f, cap_q[f], exp_q[f]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_short_frame();
        test_handshake_order();
        test_back_to_back();
        test_reset_mid_run();
        test_random_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d errors=%0d", nvec, nerr);
        $fatal(1);
    end

endmodule
